// File: rtl/sub_bytes_engine_if.sv
// Word handshake between a producer/consumer and the byte-substitution engine.
// The same interface carries the input request and the output result.
interface sub_bytes_engine_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_rot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_rot, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_rot, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sub_bytes_engine.sv
// Time-multiplexed AES SubBytes / SubWord(RotWord) engine: LANES forward S-boxes
// sweep a WIDTH-bit word over BEATS cycles, one lane group per beat.
module Sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  // Entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] LUT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_byte = LUT[i_byte];
endmodule

module sub_bytes_engine #(
  parameter int WIDTH = 128,
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  sub_bytes_engine_if.slave s_if
);
  localparam int BEATS = WIDTH / (8 * LANES);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = WIDTH / 32;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                           r_state, w_next;
  logic [CW-1:0]                    r_beat;
  logic [BEATS-1:0][LANES-1:0][7:0] r_src, r_res;
  logic [DW-1:0][31:0]              w_cap;
  logic [LANES-1:0][7:0]            w_sb_out;
  logic                             w_accept;

  // RotWord is folded into capture so the beat loop only ever sees plain bytes.
  for (genvar d = 0; d < DW; d++) begin : g_rot
    assign w_cap[d] = s_if.in_rot ? {s_if.in_data[32*d +: 24], s_if.in_data[32*d+24 +: 8]}
                                  : s_if.in_data[32*d +: 32];
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    Sbox u_sbox (.i_byte(r_src[r_beat][j]), .o_byte(w_sb_out[j]));
  end

  assign w_accept      = s_if.in_valid & s_if.in_ready;
  assign s_if.out_data = r_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (s_if.in_valid) w_next = BUSY;
      BUSY:    if (r_beat == LAST) w_next = DONE;
      DONE:    if (s_if.out_ready) w_next = s_if.in_valid ? BUSY : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_if.in_ready  = (r_state == IDLE) | ((r_state == DONE) & s_if.out_ready);
    s_if.out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
      r_src  <= '0;
      r_res  <= '0;
    end else if (w_accept) begin
      r_src  <= w_cap;
      r_beat <= '0;
    end else if (r_state == BUSY) begin
      r_res[r_beat] <= w_sb_out;
      if (r_beat != LAST) r_beat <= r_beat + CW'(1);
    end
  end
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed + randomized check of sub_bytes_engine in a 32-bit/4-lane and a
// 128-bit/1-lane configuration.
module tb_sub_bytes_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub_bytes_engine_if #(.WIDTH(32))  b32();
  sub_bytes_engine_if #(.WIDTH(128)) b128();

  sub_bytes_engine #(.WIDTH(32),  .LANES(4)) u_w32  (.clk(clk), .rst(rst), .s_if(b32.slave));
  sub_bytes_engine #(.WIDTH(128), .LANES(1)) u_w128 (.clk(clk), .rst(rst), .s_if(b128.slave));

  int n_tot = 0;
  int n_bad = 0;

  logic [127:0] q[$];
  int           sent, got, cyc;
  logic         pend;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Independent S-box: GF(2^8) inverse by search, then the affine map.
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(logic [7:0] x);
    logic [7:0] v = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_ref(logic [127:0] d, logic rot);
    logic [127:0] r;
    logic [31:0]  w;
    for (int k = 0; k < 4; k++) begin
      w = d[32*k +: 32];
      if (rot) w = {w[23:0], w[31:24]};
      for (int b = 0; b < 4; b++) r[32*k + 8*b +: 8] = sbox_ref(w[8*b +: 8]);
    end
    return r;
  endfunction

  task automatic send32(input string tag, input logic [31:0] d, input logic r, input logic [31:0] exp);
    int n;
    @(negedge clk);
    b32.in_valid = 1'b1; b32.in_data = d; b32.in_rot = r; b32.out_ready = 1'b0;
    #1 chk({tag, "_rdy"}, b32.in_ready, 1);
    @(negedge clk);
    b32.in_valid = 1'b0;
    n = 0;
    while (!b32.out_valid && n < 64) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_data"}, b32.out_data, exp);
    b32.out_ready = 1'b1;
    @(negedge clk);
    b32.out_ready = 1'b0;
    #1 chk({tag, "_idle"}, b32.out_valid, 0);
  endtask

  task automatic send128(input string tag, input logic [127:0] d, input logic r, input logic [127:0] exp);
    int   n;
    logic rdy_seen;
    @(negedge clk);
    b128.in_valid = 1'b1; b128.in_data = d; b128.in_rot = r; b128.out_ready = 1'b0;
    #1 chk({tag, "_rdy"}, b128.in_ready, 1);
    @(negedge clk);
    b128.in_valid = 1'b0;
    n = 0;
    rdy_seen = 1'b0;
    while (!b128.out_valid && n < 64) begin
      rdy_seen |= b128.in_ready;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 16);
    chk({tag, "_busy_rdy"}, rdy_seen, 0);
    chk({tag, "_data"}, b128.out_data, exp);
    b128.out_ready = 1'b1;
    @(negedge clk);
    b128.out_ready = 1'b0;
    #1 chk({tag, "_idle"}, b128.out_valid, 0);
  endtask

  initial begin
    b32.in_valid = 0;  b32.in_data = '0;  b32.in_rot = 0;  b32.out_ready = 0;
    b128.in_valid = 0; b128.in_data = '0; b128.in_rot = 0; b128.out_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ov32", b32.out_valid, 0);
    chk("rst_od32", b32.out_data, 0);
    chk("rst_rdy32", b32.in_ready, 1);
    chk("rst_ov128", b128.out_valid, 0);
    chk("rst_od128", b128.out_data, 0);
    chk("rst_rdy128", b128.in_ready, 1);

    send32("w32_plain", 32'h00015300, 1'b0, 32'h637CED63);
    send32("w32_rot",   32'h09CF4F3C, 1'b1, 32'h8A84EB01);
    send32("w32_rot2",  32'h00015300, 1'b1, 32'h7CED6363);
    send32("w32_ff",    32'hFFFFFFFF, 1'b0, 32'h16161616);

    send128("w128_vec", 128'h00102030405060708090A0B0C0D0E0F0, 1'b0,
            128'h63CAB7040953D051CD60E0E7BA70E18C);
    send128("w128_rot", 128'h00000000000000000000000000015300, 1'b1,
            128'h6363636363636363636363637CED6363);

    // Backpressure, then a back-to-back capture through DONE.
    @(negedge clk);
    b32.in_valid = 1'b1; b32.in_data = 32'h00015300; b32.in_rot = 1'b0; b32.out_ready = 1'b0;
    @(negedge clk);
    b32.in_data = 32'h09CF4F3C;
    #1 chk("bp_busy_rdy", b32.in_ready, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ov", b32.out_valid, 1);
      chk("bp_hold", b32.out_data, 32'h637CED63);
      chk("bp_rdy", b32.in_ready, 0);
      @(negedge clk);
    end
    b32.out_ready = 1'b1;
    #1 chk("b2b_rdy", b32.in_ready, 1);
    @(negedge clk);
    b32.out_ready = 1'b0; b32.in_valid = 1'b0;
    #1 chk("b2b_busy", b32.out_valid, 0);
    @(negedge clk);
    #1;
    chk("b2b_ov", b32.out_valid, 1);
    chk("b2b_data", b32.out_data, 32'h018A84EB);
    b32.out_ready = 1'b1;
    @(negedge clk);
    b32.out_ready = 1'b0;

    // Reset landing on beat 2 of a 16-beat word.
    @(negedge clk);
    b128.in_valid = 1'b1; b128.in_data = 128'h00102030405060708090A0B0C0D0E0F0; b128.in_rot = 1'b0;
    @(negedge clk);
    b128.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", b128.out_valid, 0);
    chk("mid_rst_od", b128.out_data, 0);
    chk("mid_rst_rdy", b128.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ov", b128.out_valid, 0);
    chk("post_rst_od", b128.out_data, 0);
    chk("post_rst_rdy", b128.in_ready, 1);
    send128("post_rst", 128'h00102030405060708090A0B0C0D0E0F0, 1'b0,
            128'h63CAB7040953D051CD60E0E7BA70E18C);

    // Random traffic against the reference model and an in-order queue.
    sent = 0; got = 0; cyc = 0; pend = 1'b0;
    while (got < 20 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (!pend && sent < 20 && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        b128.in_data = {$urandom, $urandom, $urandom, $urandom};
        b128.in_rot  = 1'($urandom_range(0, 1));
      end
      b128.in_valid  = pend;
      b128.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (b128.out_valid && b128.out_ready) begin
        if (q.size() == 0) chk("rnd_underflow", q.size(), 1);
        else               chk("rnd_data", b128.out_data, q.pop_front());
        got++;
      end
      if (pend && b128.in_ready) begin
        q.push_back(sub_ref(b128.in_data, b128.in_rot));
        pend = 1'b0;
        sent++;
      end
    end
    b128.in_valid = 1'b0; b128.out_ready = 1'b0;
    chk("rnd_count", got, 20);
    chk("rnd_left", q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
